// File: rtl/ring_arb_pkg.sv
// ring_arb_pkg
// Shared definitions for the ring token arbiter slice.
//   state_t      : arbiter FSM states (IDLE, BUSY)
//   N_DEF        : default number of requesters
//   HOLD_MAX_DEF : default maximum BUSY cycles per grant (only meaningful when
//                  the design is built with RING_ARB_TIMEOUT_EN defined)
//   onehot2idx   : converts a one-hot vector (up to 32 bits) into its bit index
package ring_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_DEF        = 8;
    localparam int HOLD_MAX_DEF = 16;

    // OR-ing the indices of all set bits yields the exact index for a
    // one-hot input without needing a priority chain.
    function automatic int onehot2idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_token_arbiter_rr_pick.sv
// rr_pick
// Combinational rotating-priority finder. Scans req_i upward starting at the
// bit marked by the one-hot token_i (inclusive), wrapping from N-1 to 0, and
// reports the first set request.
//   req_i     [N-1:0]        : level requests
//   token_i   [N-1:0]        : one-hot priority pointer (N <= 32)
//   win_oh_o  [N-1:0]        : one-hot winner, zero when no request
//   win_idx_o [$clog2(N)-1:0]: winner index, zero when no request
//   any_o                    : at least one request present
module rr_pick
    import ring_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0]         token_i,
    output logic [N-1:0]         win_oh_o,
    output logic [$clog2(N)-1:0] win_idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);

    int          tokIdx;
    logic [IW-1:0] pos;
    logic        found;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        pos       = '0;
        tokIdx    = onehot2idx(32'(token_i));
        for (int k = 0; k < N; k++) begin
            pos = IW'((tokIdx + k) % N);
            if (!found && req_i[pos]) begin
                found         = 1'b1;
                win_oh_o[pos] = 1'b1;
                win_idx_o     = pos;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter
// Round-robin arbiter with a one-hot ring token as the rotating priority
// pointer. One registered one-hot grant at a time; the token free-runs while
// idle and jumps just past the owner on release, so nobody starves.
// Optional feature macro: RING_ARB_TIMEOUT_EN -- when defined, a hold counter
// forces release after HOLD_MAX BUSY cycles and pulses timeout_o.
//   clk_i         : rising-edge clock
//   rst_ni        : asynchronous active-low reset
//   req_i         [N-1:0] : level requests, held for the whole transaction
//   grant_o       [N-1:0] : registered one-hot grant, or zero
//   grant_valid_o         : |grant_o
//   owner_o       [$clog2(N)-1:0] : index of the granted requester (sticky)
//   token_o       [N-1:0] : current one-hot priority pointer
//   timeout_o             : one-cycle pulse on forced release
module ring_token_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         grant_o,
    output logic                 grant_valid_o,
    output logic [$clog2(N)-1:0] owner_o,
    output logic [N-1:0]         token_o,
    output logic                 timeout_o
);

    localparam int IW = $clog2(N);

    if (N < 2) begin : gBadN
        $error("ring_token_arbiter needs N >= 2");
    end
    if (HOLD_MAX < 1) begin : gBadHold
        $error("ring_token_arbiter needs HOLD_MAX >= 1");
    end

    state_t        state_q;
    logic [N-1:0]  token_q;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] owner_q;

    logic [N-1:0]  pickOh;
    logic [IW-1:0] pickIdx;
    logic          pickAny;
    logic          ownerReq;
    logic          forcedRel;
    logic          releaseD;

    rr_pick #(.N(N)) uPick (
        .req_i     (req_i),
        .token_i   (token_q),
        .win_oh_o  (pickOh),
        .win_idx_o (pickIdx),
        .any_o     (pickAny)
    );

    assign ownerReq = req_i[owner_q];

`ifdef RING_ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0] hold_q;
    logic          timeout_q;

    // hold_q counts completed BUSY cycles minus one, so reaching HOLD_MAX-1
    // on an edge means the grant has been visible for HOLD_MAX cycles.
    assign forcedRel = (hold_q == HW'(HOLD_MAX - 1));
    assign timeout_o = timeout_q;
`else
    assign forcedRel = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign releaseD = !ownerReq || forcedRel;

    // FSM, token ring, grant/owner registers and optional hold counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            token_q   <= N'(1);
            grant_q   <= '0;
            owner_q   <= '0;
`ifdef RING_ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RING_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pickAny) begin
                        grant_q <= pickOh;
                        owner_q <= pickIdx;
                        state_q <= BUSY;
`ifdef RING_ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end else begin
                        token_q <= {token_q[N-2:0], token_q[N-1]};
                    end
                end
                BUSY: begin
                    if (releaseD) begin
                        // grant_q is the owner's one-hot; rotate it to move
                        // priority just past the releasing owner.
                        grant_q   <= '0;
                        token_q   <= {grant_q[N-2:0], grant_q[N-1]};
                        state_q   <= IDLE;
`ifdef RING_ARB_TIMEOUT_EN
                        timeout_q <= ownerReq;
`endif
                    end else begin
`ifdef RING_ARB_TIMEOUT_EN
                        hold_q    <= hold_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = |grant_q;
    assign owner_o       = owner_q;
    assign token_o       = token_q;

endmodule
